div_clk_monitor: RTL and testbench

Receiving end of the divided-clock path. Takes a slow clock produced by a divider, which is asynchronous to the local domain, into the local clk domain. It emits a one-cycle tick per rising edge, measures the period in local clk cycles, counts edges and flags a stalled or missing divided clock. Used to check the divider output on the board and to drive logic with slow-rate enables instead of a derived clock.

---
 rtl/div_clk_monitor_pkg.sv | 14 +
 rtl/sync_rise_det.sv | 27 ++
 rtl/div_clk_monitor.sv | 97 +++++++++
 tb/tb_div_clk_monitor.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_clk_monitor_pkg.sv
// Shared types and defaults for the divided-clock monitor.
package div_clk_monitor_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      STALL = 2'd2
   } state_t;

   localparam int unsigned DEFAULT_CNT_W   = 28;
   localparam int unsigned DEFAULT_EDGE_W  = 16;
   localparam int unsigned DEFAULT_TIMEOUT = 150_000_000;

endpackage

// File: rtl/sync_rise_det.sv
// Two-flop synchronizer plus edge register; flags one rising edge of an async input.
module sync_rise_det (
   input  logic clk,
   input  logic rst,
   input  logic d_async,
   output logic rise
);

   logic s1;
   logic s2;
   logic s3;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= d_async;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;

endmodule

// File: rtl/div_clk_monitor.sv
// Observes an asynchronous divided clock: per-edge tick, period measurement,
// edge count and stall detection in the local clk domain.
module div_clk_monitor
   import div_clk_monitor_pkg::*;
#(
   parameter int unsigned CNT_W   = DEFAULT_CNT_W,
   parameter int unsigned EDGE_W  = DEFAULT_EDGE_W,
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clk_div_in,
   output logic              tick,
   output logic [CNT_W-1:0]  period,
   output logic              period_valid,
   output logic [EDGE_W-1:0] edge_cnt,
   output logic              timeout,
   output logic              locked
);

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

   logic             rise;
   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] per_cnt;
   logic [CNT_W-1:0] period_d;
   logic             period_valid_d;
   logic             timeout_d;

   sync_rise_det u_sync (
      .clk     (clk),
      .rst     (rst),
      .d_async (clk_div_in),
      .rise    (rise)
   );

   // Next-state and measurement updates; a rise always beats the timeout.
   always_comb begin
      state_d        = state_q;
      period_d       = period;
      period_valid_d = period_valid;
      timeout_d      = timeout;
      case (state_q)
         IDLE: begin
            if (rise) state_d = ARMED;
         end
         ARMED: begin
            if (rise) begin
               period_d       = per_cnt + CNT_W'(1);
               period_valid_d = 1'b1;
            end else if (per_cnt == TO_LAST) begin
               state_d        = STALL;
               timeout_d      = 1'b1;
               period_valid_d = 1'b0;
            end
         end
         STALL: begin
            if (rise) begin
               state_d   = ARMED;
               timeout_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         per_cnt      <= '0;
         tick         <= 1'b0;
         period       <= '0;
         period_valid <= 1'b0;
         edge_cnt     <= '0;
         timeout      <= 1'b0;
         locked       <= 1'b0;
      end else begin
         state_q      <= state_d;
         tick         <= rise;
         period       <= period_d;
         period_valid <= period_valid_d;
         timeout      <= timeout_d;
         locked       <= (state_d == ARMED);
         if (rise) begin
            edge_cnt <= edge_cnt + EDGE_W'(1);
         end
         // Interval counter restarts on each rise and saturates rather than wrapping.
         if (rise) begin
            per_cnt <= '0;
         end else if (!(&per_cnt)) begin
            per_cnt <= per_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_div_clk_monitor.sv
// Scoreboard bench for div_clk_monitor with a short timeout and narrow edge counter.
module tb_div_clk_monitor;

   localparam int unsigned CNT_W   = 28;
   localparam int unsigned EDGE_W  = 4;
   localparam int unsigned TIMEOUT = 20;

   typedef struct packed {
      logic [CNT_W-1:0]  period;
      logic              pv;
      logic [EDGE_W-1:0] ecnt;
      logic              locked;
      logic              to;
   } exp_t;

   typedef struct {
      int               cyc;
      logic             to;
      logic [CNT_W-1:0] per;
   } probe_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              clk_div_in = 1'b0;
   logic              tick;
   logic [CNT_W-1:0]  period;
   logic              period_valid;
   logic [EDGE_W-1:0] edge_cnt;
   logic              timeout;
   logic              locked;

   exp_t   exp_q[$];
   probe_t probe_q[$];
   int     vectors     = 0;
   int     miscompares = 0;
   int     cyc         = 0;
   int     tick_cnt    = 0;
   int     tick_base   = 0;

   logic              m_armed;
   logic [CNT_W-1:0]  m_period;
   logic              m_valid;
   logic [EDGE_W-1:0] m_edge;
   int                m_last;

   div_clk_monitor #(
      .CNT_W   (CNT_W),
      .EDGE_W  (EDGE_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .clk_div_in   (clk_div_in),
      .tick         (tick),
      .period       (period),
      .period_valid (period_valid),
      .edge_cnt     (edge_cnt),
      .timeout      (timeout),
      .locked       (locked)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endfunction

   task automatic check_zero(string tag);
      chk({tag, "_tick"},     64'(tick),         64'd0);
      chk({tag, "_period"},   64'(period),       64'd0);
      chk({tag, "_pvalid"},   64'(period_valid), 64'd0);
      chk({tag, "_edge_cnt"}, 64'(edge_cnt),     64'd0);
      chk({tag, "_timeout"},  64'(timeout),      64'd0);
      chk({tag, "_locked"},   64'(locked),       64'd0);
   endtask

   // One clk cycle; fires any timeout probes due on this cycle.
   task automatic step();
      probe_t p;
      @(negedge clk);
      cyc++;
      while (probe_q.size() > 0 && probe_q[0].cyc == cyc) begin
         p = probe_q.pop_front();
         chk($sformatf("timeout_at_%0d", cyc), 64'(timeout), 64'(p.to));
         if (p.to) begin
            chk($sformatf("stall_pvalid_at_%0d", cyc), 64'(period_valid), 64'd0);
            chk($sformatf("stall_period_at_%0d", cyc), 64'(period), 64'(p.per));
         end else begin
            chk($sformatf("locked_at_%0d", cyc), 64'(locked), 64'd1);
         end
      end
   endtask

   task automatic model_reset();
      m_armed  = 1'b0;
      m_period = '0;
      m_valid  = 1'b0;
      m_edge   = '0;
      m_last   = cyc;
      exp_q.delete();
      probe_q.delete();
   endtask

   // Expected outputs at the tick produced by a rise driven this cycle.
   task automatic model_rise();
      int gap;
      gap    = cyc - m_last;
      m_last = cyc;
      if (!m_armed) begin
         m_armed = 1'b1;
         m_valid = 1'b0;
      end else if (gap <= int'(TIMEOUT)) begin
         m_period = CNT_W'(gap);
         m_valid  = 1'b1;
      end else begin
         m_valid = 1'b0;
      end
      m_edge = m_edge + EDGE_W'(1);
      exp_q.push_back('{m_period, m_valid, m_edge, 1'b1, 1'b0});
   endtask

   // One divided-clock cycle; optional probes around the timeout point of this interval.
   task automatic wave(int hi, int lo, bit probe);
      clk_div_in = 1'b1;
      model_rise();
      if (probe) begin
         probe_q.push_back('{cyc + 22, 1'b0, m_period});
         probe_q.push_back('{cyc + 23, logic'(hi + lo > int'(TIMEOUT)), m_period});
      end
      repeat (hi) step();
      clk_div_in = 1'b0;
      repeat (lo) step();
   endtask

   task automatic monitor();
      exp_t e;
      exp_t a;
      forever begin
         @(negedge clk);
         if (!rst && tick === 1'b1) begin
            tick_cnt++;
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL tick_%0d: unexpected tick (no pending edge)", tick_cnt);
            end else begin
               e = exp_q.pop_front();
               a = '{period, period_valid, edge_cnt, locked, timeout};
               if (a !== e) begin
                  miscompares++;
                  $display("FAIL tick_%0d: got period=%0d pv=%0b edge=%0d locked=%0b to=%0b expected period=%0d pv=%0b edge=%0d locked=%0b to=%0b",
                           tick_cnt, a.period, a.pv, a.ecnt, a.locked, a.to,
                           e.period, e.pv, e.ecnt, e.locked, e.to);
               end
            end
         end
      end
   endtask

   initial begin
      fork
         monitor();
      join_none

      // Reset held while the input toggles
      model_reset();
      for (int i = 0; i < 12; i++) begin
         step();
         if (i % 2 == 0) clk_div_in = ~clk_div_in;
      end
      check_zero("reset_hold");
      clk_div_in = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      model_reset();
      repeat (2) step();

      // Steady 4/4 wave
      repeat (4) wave(4, 4, 1'b0);

      // Stall: 34-cycle gap, late rise, then normal period again
      wave(4, 30, 1'b1);
      wave(4, 4, 1'b0);
      wave(4, 4, 1'b0);

      // Boundary: gap of exactly TIMEOUT, then TIMEOUT+1
      wave(4, 16, 1'b1);
      wave(4, 17, 1'b1);
      wave(4, 4, 1'b0);
      wave(4, 4, 1'b0);

      // Jitter: 7/9 alternating
      for (int i = 0; i < 3; i++) begin
         wave(4, 3, 1'b0);
         wave(4, 5, 1'b0);
      end
      repeat (6) step();
      chk("queue_drained", 64'(exp_q.size()), 64'd0);

      // Async reset mid-measurement, between clk edges
      clk_div_in = 1'b1;
      model_rise();
      repeat (6) step();
      #2;
      rst = 1'b1;
      #1;
      check_zero("async_reset");
      model_reset();
      clk_div_in = 1'b0;
      repeat (2) step();
      rst = 1'b0;
      model_reset();
      tick_base = tick_cnt;
      repeat (2) step();

      // Edge counter wrap over 17 edges
      repeat (17) wave(2, 2, 1'b0);
      repeat (6) step();
      chk("wrap_edge_cnt",   64'(edge_cnt),             64'd1);
      chk("wrap_tick_count", 64'(tick_cnt - tick_base), 64'd17);
      chk("queue_final",     64'(exp_q.size()),         64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
